// File: rtl/raw10_ctrl_pkg.sv
// Shared types and constants for the RAW10 frame/line sequencer.
// Error codes are ordered so that a larger value means a higher reporting priority.
package raw10_ctrl_pkg;

    localparam int unsigned lane_width_default = 4;

    typedef enum logic [2:0] {
        IDLE,
        FRAME,
        LINE,
        GAP,
        TAIL
    } ctrl_state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_SEQ   = 2'd1,
        ERR_WC    = 2'd2,
        ERR_TRUNC = 2'd3
    } err_t;

endpackage

// File: rtl/raw10_down_timer.sv
// Loadable down-counter; done is high during the last counted cycle (value 1),
// so a load of N keeps the owner busy for exactly N cycles.
module raw10_down_timer #(
    parameter int unsigned width = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [width-1:0] load_val,
    output logic             done
);

    logic [width-1:0] cnt;

    // NOTE: sequential state is written only with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - width'(1);
        end
    end

    assign done = (cnt == width'(1));

endmodule

// File: rtl/raw10_frame_ctrl.sv
// Frame/line sequencer driving fv_8bit/lv_8bit of the 4-lane RAW10 converter from
// decoded CSI-2 packet events, with line/frame counting and protocol-error pulses.
module raw10_frame_ctrl
    import raw10_ctrl_pkg::*;
#(
    parameter int unsigned lane_width = lane_width_default,
    parameter int unsigned wc_width   = 16,
    parameter int unsigned lv_gap     = 4,
    parameter int unsigned fv_tail    = 8,
    parameter int unsigned line_bits  = 12
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 fs,
    input  logic                 fe,
    input  logic                 lp_start,
    input  logic [wc_width-1:0]  wc,
    input  logic                 payload_en,
    output logic                 fv_8bit,
    output logic                 lv_8bit,
    output logic [line_bits-1:0] line_cnt,
    output logic [line_bits-1:0] last_lines,
    output logic [15:0]          frame_cnt,
    output logic                 err_seq,
    output logic                 err_trunc,
    output logic                 err_wc
);

    localparam int unsigned lane_shift = $clog2(lane_width);
    localparam int unsigned gap_w      = $clog2(lv_gap + 1);
    localparam int unsigned tail_w     = $clog2(fv_tail + 1);

    ctrl_state_t         state, state_nxt;
    err_t                err_nxt;
    logic [wc_width-1:0] beat_cnt;
    logic [wc_width:0]   wc_round;
    logic [wc_width-1:0] beats;
    logic                fe_pend;
    logic                beat_load, beat_dec, line_inc, gap_load, tail_load, frame_done;
    logic                lv_nxt, seq_c, wc_c, trunc_c;
    logic                gap_done, tail_done;

    // Round the byte count up to whole beats; the extra bit absorbs the carry.
    assign wc_round = {1'b0, wc} + (wc_width + 1)'(lane_width - 1);
    assign beats    = wc_width'(wc_round >> lane_shift);

    raw10_down_timer #(.width(gap_w)) u_gap_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (gap_load),
        .load_val (gap_w'(lv_gap)),
        .done     (gap_done)
    );

    raw10_down_timer #(.width(tail_w)) u_tail_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (tail_load),
        .load_val (tail_w'(fv_tail)),
        .done     (tail_done)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        beat_load  = 1'b0;
        beat_dec   = 1'b0;
        line_inc   = 1'b0;
        gap_load   = 1'b0;
        tail_load  = 1'b0;
        frame_done = 1'b0;
        lv_nxt     = 1'b0;
        seq_c      = 1'b0;
        wc_c       = 1'b0;
        trunc_c    = 1'b0;

        unique case (state)
            IDLE: begin
                if (fs) state_nxt = FRAME;
                seq_c = fe | lp_start | payload_en;
            end
            FRAME: begin
                if (fe) begin
                    tail_load = 1'b1;
                    state_nxt = TAIL;
                    seq_c     = fs | lp_start | payload_en;
                end else if (lp_start) begin
                    if (wc != '0) begin
                        beat_load = 1'b1;
                        state_nxt = LINE;
                    end else begin
                        wc_c = 1'b1;
                    end
                    seq_c = fs | payload_en;
                end else begin
                    seq_c = fs | payload_en;
                end
            end
            LINE: begin
                if (fe) begin
                    trunc_c   = 1'b1;
                    tail_load = 1'b1;
                    state_nxt = TAIL;
                end else if (lp_start) begin
                    seq_c = 1'b1;
                end else begin
                    seq_c = fs;
                    if (payload_en) begin
                        beat_dec = 1'b1;
                        lv_nxt   = 1'b1;
                        if (beat_cnt == wc_width'(1)) begin
                            line_inc  = 1'b1;
                            gap_load  = 1'b1;
                            state_nxt = GAP;
                        end
                    end
                end
            end
            GAP: begin
                // A frame end seen here is honoured only once the gap has elapsed.
                seq_c = fs | lp_start | payload_en;
                if (gap_done) begin
                    if (fe || fe_pend) begin
                        tail_load = 1'b1;
                        state_nxt = TAIL;
                    end else begin
                        state_nxt = FRAME;
                    end
                end
            end
            TAIL: begin
                seq_c = fs | fe | lp_start | payload_en;
                if (tail_done) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (trunc_c)    err_nxt = ERR_TRUNC;
        else if (wc_c)  err_nxt = ERR_WC;
        else if (seq_c) err_nxt = ERR_SEQ;
        else            err_nxt = ERR_NONE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            fe_pend    <= 1'b0;
            line_cnt   <= '0;
            last_lines <= '0;
            frame_cnt  <= '0;
            fv_8bit    <= 1'b0;
            lv_8bit    <= 1'b0;
            err_seq    <= 1'b0;
            err_trunc  <= 1'b0;
            err_wc     <= 1'b0;
        end else begin
            state   <= state_nxt;
            fe_pend <= (state == GAP && state_nxt == GAP) ? (fe_pend | fe) : 1'b0;

            if (beat_load)     beat_cnt <= beats;
            else if (beat_dec) beat_cnt <= beat_cnt - wc_width'(1);

            if (frame_done) begin
                last_lines <= line_cnt;
                line_cnt   <= '0;
                frame_cnt  <= frame_cnt + 16'd1;
            end else if (line_inc && line_cnt != '1) begin
                line_cnt <= line_cnt + line_bits'(1);
            end

            fv_8bit   <= (state_nxt != IDLE);
            lv_8bit   <= lv_nxt;
            err_seq   <= (err_nxt == ERR_SEQ);
            err_wc    <= (err_nxt == ERR_WC);
            err_trunc <= (err_nxt == ERR_TRUNC);
        end
    end

endmodule

// File: tb/tb_raw10_frame_ctrl.sv
// Directed bench for raw10_frame_ctrl (lane_width 4, lv_gap 4, fv_tail 8): inputs change
// 1 ns after each rising edge and outputs are compared at that same point.
module tb_raw10_frame_ctrl;

    logic        clk;
    logic        rstn;
    logic        fs;
    logic        fe;
    logic        lp_start;
    logic [15:0] wc;
    logic        payload_en;
    logic        fv_8bit;
    logic        lv_8bit;
    logic [11:0] line_cnt;
    logic [11:0] last_lines;
    logic [15:0] frame_cnt;
    logic        err_seq;
    logic        err_trunc;
    logic        err_wc;

    int pass_cnt  = 0;
    int check_cnt = 0;

    raw10_frame_ctrl #(
        .lane_width (4),
        .wc_width   (16),
        .lv_gap     (4),
        .fv_tail    (8),
        .line_bits  (12)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .fs         (fs),
        .fe         (fe),
        .lp_start   (lp_start),
        .wc         (wc),
        .payload_en (payload_en),
        .fv_8bit    (fv_8bit),
        .lv_8bit    (lv_8bit),
        .line_cnt   (line_cnt),
        .last_lines (last_lines),
        .frame_cnt  (frame_cnt),
        .err_seq    (err_seq),
        .err_trunc  (err_trunc),
        .err_wc     (err_wc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rstn = 1'b0; fs = 1'b0; fe = 1'b0; lp_start = 1'b0; wc = '0; payload_en = 1'b0;
        tick();
        tick();
        check("rst_fv", 32'(fv_8bit), 0);
        check("rst_lv", 32'(lv_8bit), 0);
        check("rst_line_cnt", 32'(line_cnt), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        check("rst_errs", 32'({err_seq, err_trunc, err_wc}), 0);
        rstn = 1'b1;
        tick();

        // Frame 1: one 20-byte line (5 beats), then fe and an 8-cycle tail.
        fs = 1'b1; tick(); fs = 1'b0;
        check("f1_fv_rise", 32'(fv_8bit), 1);
        lp_start = 1'b1; wc = 16'd20; tick(); lp_start = 1'b0;
        check("f1_lv_hdr", 32'(lv_8bit), 0);
        payload_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("f1_lv_beat", 32'(lv_8bit), 1);
        end
        payload_en = 1'b0;
        check("f1_line_cnt", 32'(line_cnt), 1);
        tick();
        check("f1_lv_low", 32'(lv_8bit), 0);
        tick(); tick(); tick();
        fe = 1'b1; tick(); fe = 1'b0;
        check("f1_fe_noerr", 32'({err_seq, err_trunc, err_wc}), 0);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("f1_fv_tail", 32'(fv_8bit), 1);
        end
        tick();
        check("f1_fv_fall", 32'(fv_8bit), 0);
        check("f1_last_lines", 32'(last_lines), 1);
        check("f1_frame_cnt", 32'(frame_cnt), 1);
        check("f1_line_clr", 32'(line_cnt), 0);

        // Frame 2: wc=10 gives 3 beats; a 4th beat and an early header land in GAP.
        tick();
        fs = 1'b1; tick(); fs = 1'b0;
        lp_start = 1'b1; wc = 16'd10; tick(); lp_start = 1'b0;
        payload_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("f2_lv_beat", 32'(lv_8bit), 1);
        end
        check("f2_line_cnt", 32'(line_cnt), 1);
        tick(); payload_en = 1'b0;
        check("f2_extra_lv", 32'(lv_8bit), 0);
        check("f2_extra_seq", 32'(err_seq), 1);
        tick();
        check("f2_seq_clear", 32'(err_seq), 0);
        lp_start = 1'b1; wc = 16'd20; tick(); lp_start = 1'b0;
        check("f2_gap_hdr_seq", 32'(err_seq), 1);
        check("f2_gap_hdr_lines", 32'(line_cnt), 1);
        check("f2_gap_hdr_lv", 32'(lv_8bit), 0);
        tick();
        check("f2_frame_noerr", 32'(err_seq), 0);
        lp_start = 1'b1; wc = 16'd0; tick(); lp_start = 1'b0;
        check("f2_wc0_err_wc", 32'(err_wc), 1);
        check("f2_wc0_err_seq", 32'(err_seq), 0);
        lp_start = 1'b1; wc = 16'd8; tick(); lp_start = 1'b0;
        check("f2_wc_clear", 32'(err_wc), 0);
        payload_en = 1'b1; tick(); tick(); payload_en = 1'b0;
        check("f2_line_cnt2", 32'(line_cnt), 2);
        fe = 1'b1; tick(); fe = 1'b0;
        check("f2_fe_gap_noerr", 32'(err_seq), 0);
        tick(); tick(); tick();
        for (int i = 0; i < 7; i++) begin
            tick();
            check("f2_fv_tail", 32'(fv_8bit), 1);
        end
        tick();
        check("f2_fv_fall", 32'(fv_8bit), 0);
        check("f2_last_lines", 32'(last_lines), 2);
        check("f2_frame_cnt", 32'(frame_cnt), 2);

        // Frame 3: fe (with a competing beat) after 2 of 5 beats truncates the line.
        fs = 1'b1; tick(); fs = 1'b0;
        lp_start = 1'b1; wc = 16'd20; tick(); lp_start = 1'b0;
        payload_en = 1'b1; tick(); tick();
        check("f3_line_cnt", 32'(line_cnt), 0);
        fe = 1'b1; tick(); fe = 1'b0; payload_en = 1'b0;
        check("f3_trunc", 32'(err_trunc), 1);
        check("f3_trunc_only", 32'(err_seq), 0);
        check("f3_lv_drop", 32'(lv_8bit), 0);
        tick();
        check("f3_trunc_pulse", 32'(err_trunc), 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("f3_fv_tail", 32'(fv_8bit), 1);
        end
        tick();
        check("f3_fv_fall", 32'(fv_8bit), 0);
        check("f3_last_lines", 32'(last_lines), 0);
        check("f3_frame_cnt", 32'(frame_cnt), 3);

        // Frame 4: reset mid-line clears everything at once, then a clean frame follows.
        fs = 1'b1; tick(); fs = 1'b0;
        lp_start = 1'b1; wc = 16'd40; tick(); lp_start = 1'b0;
        payload_en = 1'b1; tick(); tick();
        check("f4_lv_mid", 32'(lv_8bit), 1);
        payload_en = 1'b0;
        rstn = 1'b0; #1;
        check("f4_rst_fv", 32'(fv_8bit), 0);
        check("f4_rst_lv", 32'(lv_8bit), 0);
        check("f4_rst_frame_cnt", 32'(frame_cnt), 0);
        check("f4_rst_last_lines", 32'(last_lines), 0);
        #2 rstn = 1'b1;
        tick();
        fs = 1'b1; tick(); fs = 1'b0;
        check("f4_fv_rise", 32'(fv_8bit), 1);
        check("f4_frame_cnt0", 32'(frame_cnt), 0);
        lp_start = 1'b1; wc = 16'd4; tick(); lp_start = 1'b0;
        payload_en = 1'b1; tick(); payload_en = 1'b0;
        check("f4_line_cnt", 32'(line_cnt), 1);
        tick(); tick(); tick(); tick();
        fe = 1'b1; tick(); fe = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("f4_fv_fall", 32'(fv_8bit), 0);
        check("f4_frame_cnt1", 32'(frame_cnt), 1);
        check("f4_last_lines", 32'(last_lines), 1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
